// File: rtl/boot_writer_pkg.sv
// Shared constants, command bytes and FSM state type for the UART boot writer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro: BOOT_WRITER_CKSUM_EN adds SUM_TX state.
package boot_writer_pkg;

  // Command bytes recognised in IDLE
  localparam logic [7:0] CMD_ADDR  = 8'h61;  // 'a'
  localparam logic [7:0] CMD_DATA  = 8'h64;  // 'd'
  localparam logic [7:0] CMD_COUNT = 8'h63;  // 'c'
  localparam logic [7:0] CMD_JUMP  = 8'h6A;  // 'j'
  localparam logic [7:0] CMD_SUM   = 8'h73;  // 's'

  localparam logic [7:0]  ACK_CHAR_DEFAULT   = 8'h66;  // 'f'
  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_COUNT,
    WRITE,
    ACK
`ifdef BOOT_WRITER_CKSUM_EN
    , SUM_TX
`endif
  } state_t;

`ifdef BOOT_WRITER_CKSUM_EN
  // Byte idx of a word, idx 0 = most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = w[31:24];
      2'd1:    word_byte = w[23:16];
      2'd2:    word_byte = w[15:8];
      default: word_byte = w[7:0];
    endcase
  endfunction
`endif

endpackage

// File: rtl/boot_writer_word_assembler.sv
// Assembles four bytes into a big-endian 32-bit word (first byte -> [31:24]).
// Latency: word/word_done are combinational on the 4th byte strobe.
// Backpressure: none; caller gates byte_valid. Ports: clk, rst_n, clear, byte_valid, byte_data -> word, word_done.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_data};
      cnt_q   <= cnt_q + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  // The 4th byte completes the word in the same cycle so the FSM can act on it directly.
  assign word      = {shift_q, byte_data};
  assign word_done = byte_valid && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/boot_writer.sv
// UART-driven boot loader: decodes a/d/c/j commands, writes words to memory, acks with ACK_CHAR.
// Latency: mem_we / tx_valid / jump_valid rise the cycle after the completing rx byte.
// Backpressure: mem_we held until mem_ready, tx_valid held until tx_ready; rx bytes arriving then are dropped (overrun).
// Ports: clk, rst_n; rx_data/rx_valid in; tx_data/tx_valid/tx_ready; mem_we/mem_addr/mem_wdata/mem_ready;
// jump_valid/jump_addr; overrun. Optional macro BOOT_WRITER_CKSUM_EN enables the 's' checksum readback.
module boot_writer
  import boot_writer_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter logic [7:0]  ACK_CHAR   = ACK_CHAR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        jump_valid,
  output logic [31:0] jump_addr,
  output logic        overrun
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [7:0]  tx_data_d;
  logic        tx_valid_d, mem_we_d, jump_d, overrun_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
`ifdef BOOT_WRITER_CKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [1:0]  sum_idx_q, sum_idx_d;
`endif

  logic        in_get;
  logic [31:0] word;
  logic        word_done;

  assign in_get = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_COUNT);

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!in_get),
    .byte_valid (rx_valid && in_get),
    .byte_data  (rx_data),
    .word       (word),
    .word_done  (word_done)
  );

  assign jump_addr = addr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    tx_valid_d  = tx_valid;
    tx_data_d   = tx_data;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    jump_d      = 1'b0;
    overrun_d   = overrun;
`ifdef BOOT_WRITER_CKSUM_EN
    sum_d       = sum_q;
    sum_idx_d   = sum_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_ADDR:  state_d = GET_ADDR;
            CMD_DATA: begin
              state_d     = GET_DATA;
              remaining_d = 32'd1;
            end
            CMD_COUNT: state_d = GET_COUNT;
            CMD_JUMP:  jump_d  = 1'b1;
`ifdef BOOT_WRITER_CKSUM_EN
            CMD_SUM: begin
              state_d    = SUM_TX;
              tx_valid_d = 1'b1;
              tx_data_d  = sum_q[31:24];
              sum_idx_d  = 2'd0;
            end
`endif
            default: ;  // unknown command: silently ignored
          endcase
        end
      end
      GET_ADDR: begin
        if (word_done) begin
          addr_d     = word;
          state_d    = ACK;
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_CHAR;
        end
      end
      GET_COUNT: begin
        if (word_done) begin
          if (word == 32'd0) begin
            state_d    = ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_CHAR;
          end else begin
            state_d     = GET_DATA;
            remaining_d = word;
          end
        end
      end
      GET_DATA: begin
        if (word_done) begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = word;
        end
      end
      WRITE: begin
        if (rx_valid) overrun_d = 1'b1;
        if (mem_ready) begin
          mem_we_d    = 1'b0;
          addr_d      = addr_q + 32'd4;
          remaining_d = remaining_q - 32'd1;
`ifdef BOOT_WRITER_CKSUM_EN
          sum_d       = sum_q + mem_wdata;
`endif
          // tx_valid only rises as mem_we falls, so the two never overlap.
          if (remaining_q == 32'd1) begin
            state_d    = ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_CHAR;
          end else begin
            state_d = GET_DATA;
          end
        end
      end
      ACK: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
`ifdef BOOT_WRITER_CKSUM_EN
      SUM_TX: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_ready) begin
          if (sum_idx_q == 2'd3) begin
            tx_valid_d = 1'b0;
            sum_d      = '0;
            state_d    = IDLE;
          end else begin
            sum_idx_d = sum_idx_q + 2'd1;
            tx_data_d = word_byte(sum_q, sum_idx_q + 2'd1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= RESET_ADDR;
      remaining_q <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      jump_valid  <= 1'b0;
      overrun     <= 1'b0;
`ifdef BOOT_WRITER_CKSUM_EN
      sum_q       <= '0;
      sum_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      tx_valid    <= tx_valid_d;
      tx_data     <= tx_data_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      jump_valid  <= jump_d;
      overrun     <= overrun_d;
`ifdef BOOT_WRITER_CKSUM_EN
      sum_q       <= sum_d;
      sum_idx_q   <= sum_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_boot_writer.sv
// Directed bench for boot_writer: command sequences with hand-computed writes, acks and flags.
// Latency: n/a. Backpressure: memory stall and tx hold are modelled by the responder below.
module tb_boot_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];
  int          stall_cycles = 0;
  int          stall_cnt = 0;
  bit          tx_hold = 1'b0;
  int          jump_cnt = 0;
  logic [31:0] jump_seen_addr = 32'hxxxx_xxxx;
  bit          overlap = 1'b0;
  bit          mem_we_seen = 1'b0;

  boot_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Responder: on the falling edge, decide ready for the coming rising edge and log handshakes.
  always @(negedge clk) begin
    if (mem_we && tx_valid) overlap = 1'b1;
    if (jump_valid) begin
      jump_cnt++;
      jump_seen_addr = jump_addr;
    end
    if (mem_we) begin
      mem_we_seen = 1'b1;
      if (stall_cnt >= stall_cycles) begin
        mem_ready = 1'b1;
        stall_cnt = 0;
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end else begin
        mem_ready = 1'b0;
        stall_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      stall_cnt = 0;
    end
    if (tx_valid && !tx_hold) begin
      tx_ready = 1'b1;
      tx_q.push_back(tx_data);
    end else begin
      tx_ready = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tx(input int n, input string name);
    for (int i = 0; i < 100 && tx_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (tx_q.size() < n) begin
      errors++;
      $display("FAIL %s: tx bytes seen %0d, required %0d", name, tx_q.size(), n);
    end
  endtask

  task automatic wait_wr(input int n, input string name);
    for (int i = 0; i < 100 && wr_addr_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (wr_addr_q.size() < n) begin
      errors++;
      $display("FAIL %s: writes seen %0d, required %0d", name, wr_addr_q.size(), n);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    mem_we_seen = 1'b0;
    jump_cnt = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({tx_valid, mem_we, jump_valid, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {tx_valid, mem_we, jump_valid, overrun});
    end
    checks++;
    if ({tx_data, mem_addr, mem_wdata} !== 72'd0) begin
      errors++;
      $display("FAIL reset_buses: tx_data=%h mem_addr=%h mem_wdata=%h, required zeros", tx_data, mem_addr, mem_wdata);
    end
    checks++;
    if (jump_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_addr: got %h, required 00000000", jump_addr);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_count_stall();
    clear_logs();
    stall_cycles = 3;
    send_byte(8'h63);
    send_word(32'h0000_0002);
    send_word(32'h1122_3344);
    wait_wr(1, "count_first_write");
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL count_early_ack: tx bytes %0d after first write, required 0", tx_q.size());
    end
    send_word(32'h5566_7788);
    wait_wr(2, "count_second_write");
    wait_tx(1, "count_ack");
    idle(5);
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 32'h0 || wr_addr_q[1] !== 32'h4) begin
      errors++;
      $display("FAIL count_addrs: %0d writes, addrs %h %h, required 2 at 00000000 00000004",
               wr_addr_q.size(), wr_addr_q[0], wr_addr_q[1]);
    end
    checks++;
    if (wr_data_q[0] !== 32'h1122_3344 || wr_data_q[1] !== 32'h5566_7788) begin
      errors++;
      $display("FAIL count_data: got %h %h, required 11223344 55667788", wr_data_q[0], wr_data_q[1]);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h66) begin
      errors++;
      $display("FAIL count_ack_byte: %0d bytes, first %h, required one 66", tx_q.size(), tx_q[0]);
    end
    stall_cycles = 0;
  endtask

  task automatic test_addr_data();
    clear_logs();
    send_byte(8'h61);
    send_word(32'h0000_1000);
    wait_tx(1, "addr_ack");
    checks++;
    if (tx_q[0] !== 8'h66 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL addr_cmd: ack %h writes %0d, required 66 and 0", tx_q[0], wr_addr_q.size());
    end
    send_byte(8'h64);
    send_word(32'hDEAD_BEEF);
    wait_wr(1, "data_write");
    wait_tx(2, "data_ack");
    checks++;
    if (wr_addr_q[0] !== 32'h0000_1000 || wr_data_q[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL data_write_val: got (%h,%h), required (00001000,DEADBEEF)", wr_addr_q[0], wr_data_q[0]);
    end
    checks++;
    if (tx_q[1] !== 8'h66) begin
      errors++;
      $display("FAIL data_ack_byte: got %h, required 66", tx_q[1]);
    end
  endtask

  task automatic test_count_zero();
    clear_logs();
    send_byte(8'h63);
    send_word(32'h0000_0000);
    wait_tx(1, "zero_ack");
    idle(3);
    checks++;
    if (tx_q[0] !== 8'h66 || mem_we_seen || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL count_zero: ack %h mem_we_seen %0d writes %0d, required 66 0 0",
               tx_q[0], mem_we_seen, wr_addr_q.size());
    end
  endtask

  task automatic test_wrap_jump();
    clear_logs();
    send_byte(8'h61);
    send_word(32'hFFFF_FFFC);
    wait_tx(1, "wrap_addr_ack");
    send_byte(8'h64);
    send_word(32'h0BAD_CAFE);
    wait_wr(1, "wrap_write");
    wait_tx(2, "wrap_ack");
    checks++;
    if (wr_addr_q[0] !== 32'hFFFF_FFFC || wr_data_q[0] !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL wrap_write_val: got (%h,%h), required (FFFFFFFC,0BADCAFE)", wr_addr_q[0], wr_data_q[0]);
    end
    checks++;
    if (jump_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_addr: got %h, required 00000000", jump_addr);
    end
    send_byte(8'h6A);
    idle(4);
    checks++;
    if (jump_cnt != 1 || jump_seen_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL jump_pulse: %0d cycles at %h, required 1 at 00000000", jump_cnt, jump_seen_addr);
    end
    checks++;
    if (tx_q.size() != 2) begin
      errors++;
      $display("FAIL jump_no_reply: tx bytes %0d, required 2", tx_q.size());
    end
  endtask

  task automatic test_overrun_reset();
    clear_logs();
    tx_hold = 1'b1;
    send_byte(8'h61);
    send_word(32'h1234_5678);
    idle(2);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h66 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_held: tx_valid %b tx_data %h overrun %b, required 1 66 0", tx_valid, tx_data, overrun);
    end
    send_byte(8'h41);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    tx_hold = 1'b0;
    wait_tx(1, "overrun_ack");
    idle(3);
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h66 || overrun !== 1'b1 || jump_addr !== 32'h1234_5678) begin
      errors++;
      $display("FAIL overrun_after: tx %0d/%h overrun %b addr %h, required 1/66 1 12345678",
               tx_q.size(), tx_q[0], overrun, jump_addr);
    end
    clear_logs();
    send_byte(8'h64);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rx_data  = 8'hBE;
    rx_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({tx_valid, mem_we, jump_valid, overrun, tx_data, mem_addr, mem_wdata, jump_addr} !== 108'd0) begin
      errors++;
      $display("FAIL midop_reset: tx_valid %b mem_we %b jump %b overrun %b tx_data %h addr %h wdata %h jaddr %h, required all 0",
               tx_valid, mem_we, jump_valid, overrun, tx_data, mem_addr, mem_wdata, jump_addr);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    send_byte(8'hEF);
    idle(10);
    checks++;
    if (mem_we_seen || tx_q.size() != 0) begin
      errors++;
      $display("FAIL midop_abandon: mem_we_seen %0d tx bytes %0d, required 0 0", mem_we_seen, tx_q.size());
    end
  endtask

`ifdef BOOT_WRITER_CKSUM_EN
  task automatic test_checksum();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    send_byte(8'h63);
    send_word(32'h0000_0002);
    send_word(32'h0000_0001);
    wait_wr(1, "sum_w1");
    send_word(32'hFFFF_FFFF);
    wait_wr(2, "sum_w2");
    wait_tx(1, "sum_count_ack");
    send_byte(8'h73);
    wait_tx(5, "sum_first");
    send_byte(8'h73);
    wait_tx(9, "sum_second");
    checks++;
    if ({tx_q[1], tx_q[2], tx_q[3], tx_q[4]} !== 32'h0) begin
      errors++;
      $display("FAIL sum_first_bytes: got %h %h %h %h, required 00 00 00 00", tx_q[1], tx_q[2], tx_q[3], tx_q[4]);
    end
    checks++;
    if ({tx_q[5], tx_q[6], tx_q[7], tx_q[8]} !== 32'h0) begin
      errors++;
      $display("FAIL sum_second_bytes: got %h %h %h %h, required 00 00 00 00", tx_q[5], tx_q[6], tx_q[7], tx_q[8]);
    end
    send_byte(8'h64);
    send_word(32'h1234_5678);
    wait_tx(10, "sum_d_ack");
    send_byte(8'h73);
    wait_tx(14, "sum_third");
    idle(4);
    checks++;
    if (tx_q.size() != 14 || {tx_q[10], tx_q[11], tx_q[12], tx_q[13]} !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sum_value: %0d bytes, got %h %h %h %h, required 14 bytes ending 12 34 56 78",
               tx_q.size(), tx_q[10], tx_q[11], tx_q[12], tx_q[13]);
    end
  endtask
`else
  task automatic test_unknown_cmd();
    clear_logs();
    send_byte(8'h73);
    send_byte(8'h41);
    idle(5);
    checks++;
    if (tx_q.size() != 0 || mem_we_seen) begin
      errors++;
      $display("FAIL unknown_cmd: tx bytes %0d mem_we_seen %0d, required 0 0", tx_q.size(), mem_we_seen);
    end
    send_byte(8'h63);
    send_word(32'h0000_0000);
    wait_tx(1, "unknown_then_ack");
    checks++;
    if (tx_q[0] !== 8'h66) begin
      errors++;
      $display("FAIL unknown_recover: got %h, required 66", tx_q[0]);
    end
  endtask
`endif

  task automatic test_no_overlap();
    checks++;
    if (overlap) begin
      errors++;
      $display("FAIL we_tx_overlap: mem_we and tx_valid high together = %0d, required 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_count_stall();
    test_addr_data();
    test_count_zero();
    test_wrap_jump();
`ifdef BOOT_WRITER_CKSUM_EN
    test_checksum();
`else
    test_unknown_cmd();
`endif
    test_overrun_reset();
    test_no_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_writer.md
BOOT_WRITER -- requirements
Module: boot_writer

Interface
REQ-001 SHALL have parameter RESET_ADDR, 32'h00000000, write-address value after reset.
REQ-002 SHALL have parameter ACK_CHAR, 8'h66 ('f'), byte transmitted to acknowledge a completed command.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  received UART byte.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-007 SHALL have port tx_data  output  8  byte to transmit.
REQ-008 SHALL have port tx_valid  output  1  tx_data valid; held until tx_ready is sampled high.
REQ-009 SHALL have port tx_ready  input  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-010 SHALL have port mem_we  output  1  memory write request; held until mem_ready is sampled high.
REQ-011 SHALL have port mem_addr  output  32  byte address of the write.
REQ-012 SHALL have port mem_wdata  output  32  write data.
REQ-013 SHALL have port mem_ready  input  1  write completes in the cycle mem_we and mem_ready are both high.
REQ-014 SHALL have port jump_valid  output  1  one-cycle pulse requesting a CPU jump.
REQ-015 SHALL have port jump_addr  output  32  jump target; equals the current address register.
REQ-016 SHALL have port overrun  output  1  sticky flag: a byte was dropped while busy.

Function
REQ-017 SHALL use these states: IDLE, GET_ADDR, GET_DATA, GET_COUNT, WRITE, ACK, plus SUM_TX when REQ-030 applies.
REQ-018 SHALL decode command bytes in IDLE: 'a'(61h)->GET_ADDR; 'd'(64h)->GET_DATA with remaining=1; 'c'(63h)->GET_COUNT; 'j'(6Ah)->pulse jump_valid next cycle and stay in IDLE; any other byte ignored, no reply.
REQ-019 SHALL assemble each word from 4 rx bytes, big-endian, first byte into bits [31:24].
REQ-020 SHALL, in GET_ADDR, load the address register on the 4th byte, then go to ACK.
REQ-021 SHALL, in GET_COUNT, load the word count N on the 4th byte; N=0 goes directly to ACK with no write; otherwise goes to GET_DATA with remaining=N.
REQ-022 SHALL, on the 4th data byte, assert mem_we in the next cycle with mem_addr=address and mem_wdata=word.
REQ-023 SHALL, on write completion, add 4 to the address (wrapping modulo 2^32) and decrement remaining; at 0 go to ACK, else return to GET_DATA.
REQ-024 SHALL, in ACK, drive tx_valid=1 and tx_data=ACK_CHAR until the byte is accepted, then go to IDLE.
REQ-025 SHALL drop any rx_valid byte arriving in WRITE, ACK or SUM_TX and set overrun, which holds until reset.
REQ-026 SHALL produce at most one write per assembled word and never assert mem_we and tx_valid in the same cycle.

Reset
REQ-027 SHALL, when rst_n is low, immediately force: state=IDLE, address=RESET_ADDR, byte counter=0, remaining=0, checksum=0, tx_valid=0, tx_data=0, mem_we=0, mem_addr=0, mem_wdata=0, jump_valid=0, overrun=0.
REQ-028 SHALL abandon any partial word, pending write or pending ACK on reset; reset mid-operation produces no further write or ACK.

Configuration
REQ-029 SHALL, without BOOT_WRITER_CKSUM_EN, treat 's'(73h) as an unknown command.
REQ-030 SHALL, with BOOT_WRITER_CKSUM_EN, keep a 32-bit wrapping sum of completed write data; 's' transmits the sum as 4 bytes MSB first through SUM_TX, clears the sum, then returns to IDLE with no ACK.

Structure
REQ-031 SHALL place the command byte constants, ACK default and state enum in package boot_writer_pkg.
REQ-032 SHALL implement byte-to-word assembly in sub-module word_assembler, which has a shift register, a 2-bit counter, a clear input and a word_done strobe.

Verification
REQ-033 SHALL test: bytes 61 00 00 10 00 -> ACK 66, no write; then bytes 64 DE AD BE EF -> write (00001000, DEADBEEF), ACK 66.
REQ-034 SHALL test: bytes 63 00 00 00 02 plus 8 data bytes, with mem_ready stalled 3 cycles per write -> writes at addresses 0 and 4, one ACK only after the second write.
REQ-035 SHALL test: bytes 63 00 00 00 00 -> ACK 66, mem_we stays 0.
REQ-036 SHALL test: address FFFFFFFC, then 'd' with one word -> write at FFFFFFFC, address wraps to 00000000; then 'j' -> jump_valid for 1 cycle with jump_addr=00000000.
REQ-037 SHALL test: byte 41 arriving during a held ACK (tx_ready=0) -> byte dropped, overrun=1; rst_n pulse during the 3rd data byte -> all outputs at reset values, no write.
REQ-038 SHALL test, with BOOT_WRITER_CKSUM_EN: write 00000001 and FFFFFFFF, then 's' -> transmits 00 00 00 00; a second 's' -> transmits 00 00 00 00.
